// File: rtl/pqcuark_keccak_stream_ctrl_pkg.sv
// Shared definitions for the Keccak stream controller: FSM state encoding,
// function-select encoding, rate lookup and message word-count helper.
package pqcuark_keccak_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_ABSORB  = 3'd2,
    ST_PERM    = 3'd3,
    ST_SQUEEZE = 3'd4,
    ST_OUT     = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    FSEL_SHA3_256 = 3'd0,
    FSEL_SHA3_512 = 3'd1,
    FSEL_SHAKE128 = 3'd2,
    FSEL_SHAKE256 = 3'd3
  } fsel_e;

  localparam int CNT_W = 5;

  // Only the four Keccak functions above are legal.
  function automatic logic fsel_legal(input logic [2:0] fsel);
    return (fsel < 3'd4);
  endfunction

  // Rate in 64-bit lanes for each function.
  function automatic logic [CNT_W-1:0] rate_words(input logic [2:0] fsel);
    logic [CNT_W-1:0] r;
    case (fsel)
      FSEL_SHA3_256: r = 5'd17;
      FSEL_SHA3_512: r = 5'd9;
      FSEL_SHAKE128: r = 5'd21;
      FSEL_SHAKE256: r = 5'd17;
      default:       r = 5'd17;
    endcase
    return r;
  endfunction

  // ceil(inlen/8) without the inlen+7 overflow.
  function automatic logic [63:0] word_count(input logic [63:0] inlen);
    return (inlen >> 3) + {63'd0, |inlen[2:0]};
  endfunction

endpackage

// File: rtl/pqcuark_keccak_stream_ctrl_if.sv
// Handshake/bus bundle of the Keccak stream controller: command, source
// stream, Keccak engine request/response and digest stream. Signal suffixes
// are from the controller's point of view.
interface pqcuark_keccak_stream_ctrl_if;

  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [63:0] cmd_inlen_i;
  logic [15:0] cmd_outlen_i;
  logic [2:0]  cmd_fsel_i;

  logic        src_valid_i;
  logic        src_ready_o;
  logic [63:0] src_data_i;

  logic        kc_init_o;
  logic [63:0] kc_inlen_o;
  logic [2:0]  kc_fsel_o;
  logic [63:0] kc_data_o;
  logic        kc_valid_o;
  logic        kc_perm_o;
  logic        kc_st_o;

  logic        kc_buffer_ready_i;
  logic        kc_perm_ready_i;
  logic [63:0] kc_dout_i;
  logic        kc_dout_valid_i;

  logic        dst_valid_o;
  logic        dst_ready_i;
  logic [63:0] dst_data_o;

  // Environment side: issues commands, feeds data, models the engine and sink.
  modport master (
    output cmd_valid_i, cmd_inlen_i, cmd_outlen_i, cmd_fsel_i,
    input  cmd_ready_o,
    output src_valid_i, src_data_i,
    input  src_ready_o,
    input  kc_init_o, kc_inlen_o, kc_fsel_o, kc_data_o, kc_valid_o, kc_perm_o, kc_st_o,
    output kc_buffer_ready_i, kc_perm_ready_i, kc_dout_i, kc_dout_valid_i,
    input  dst_valid_o, dst_data_o,
    output dst_ready_i
  );

  // Controller side.
  modport slave (
    input  cmd_valid_i, cmd_inlen_i, cmd_outlen_i, cmd_fsel_i,
    output cmd_ready_o,
    input  src_valid_i, src_data_i,
    output src_ready_o,
    output kc_init_o, kc_inlen_o, kc_fsel_o, kc_data_o, kc_valid_o, kc_perm_o, kc_st_o,
    input  kc_buffer_ready_i, kc_perm_ready_i, kc_dout_i, kc_dout_valid_i,
    output dst_valid_o, dst_data_o,
    input  dst_ready_i
  );

endinterface

// File: rtl/pqcuark_keccak_stream_ctrl.sv
// Keccak stream controller: sequences init, absorb, permutation and squeeze
// requests toward a Keccak engine and streams the digest out.
// Optional feature: PQCUARK_STREAM_PERF_EN adds perf_perm_cnt_o.
//
// state   | meaning
// IDLE    | ready for a command
// INIT    | kc_init_o pulse, job parameters latched
// ABSORB  | message words passed through to the engine
// PERM    | kc_perm_o pulse, wait for permutation to finish
// SQUEEZE | kc_st_o pulse, wait for an output lane
// OUT     | present held lane on the digest stream
// DONE    | done_o pulse
module pqcuark_keccak_stream_ctrl
  import pqcuark_keccak_stream_ctrl_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          flush_i,
  pqcuark_keccak_stream_ctrl_if.slave   bus,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
`ifdef PQCUARK_STREAM_PERF_EN
  ,
  output logic [31:0]                   perf_perm_cnt_o
`endif
);

  state_e            state_q;
  logic [63:0]       rem_q;
  logic [CNT_W-1:0]  blk_q;
  logic [CNT_W-1:0]  sq_q;
  logic [15:0]       outlen_q;
  logic [63:0]       inlen_q;
  logic [2:0]        fsel_q;
  logic [63:0]       hold_q;
  logic              init_q;
  logic              perm_q;
  logic              st_q;
  logic              done_q;
  logic              err_q;

  logic              absorb_fire_d;
  logic [63:0]       rem_dec_d;
  logic [CNT_W-1:0]  blk_inc_d;
  logic [CNT_W-1:0]  sq_inc_d;
  logic [15:0]       outlen_dec_d;
  logic [CNT_W-1:0]  rate_d;

  // Counter arithmetic shared by the FSM transitions.
  always_comb begin
    absorb_fire_d = (state_q == ST_ABSORB) & bus.src_valid_i & bus.kc_buffer_ready_i;
    rem_dec_d     = rem_q - 64'd1;
    blk_inc_d     = blk_q + 5'd1;
    sq_inc_d      = sq_q + 5'd1;
    outlen_dec_d  = outlen_q - 16'd1;
    rate_d        = rate_words(fsel_q);
  end

  assign bus.cmd_ready_o = (state_q == ST_IDLE);
  assign bus.src_ready_o = (state_q == ST_ABSORB) & bus.kc_buffer_ready_i;
  assign bus.kc_valid_o  = absorb_fire_d;
  assign bus.kc_data_o   = bus.src_data_i;
  assign bus.kc_init_o   = init_q;
  assign bus.kc_perm_o   = perm_q;
  assign bus.kc_st_o     = st_q;
  assign bus.kc_inlen_o  = inlen_q;
  assign bus.kc_fsel_o   = fsel_q;
  assign bus.dst_valid_o = (state_q == ST_OUT);
  assign bus.dst_data_o  = hold_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;
  assign err_o           = err_q;

  // Main sequencer; request pulses are set on entry to their state so they
  // last exactly one cycle. Engine handshakes are only honoured after the
  // request pulse, so a stale ready/valid cannot short-circuit a request.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      blk_q    <= '0;
      sq_q     <= '0;
      outlen_q <= '0;
      inlen_q  <= '0;
      fsel_q   <= '0;
      hold_q   <= '0;
      init_q   <= 1'b0;
      perm_q   <= 1'b0;
      st_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      init_q <= 1'b0;
      perm_q <= 1'b0;
      st_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (flush_i) begin
        state_q  <= ST_IDLE;
        rem_q    <= '0;
        blk_q    <= '0;
        sq_q     <= '0;
        outlen_q <= '0;
        hold_q   <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.cmd_valid_i) begin
              if (fsel_legal(bus.cmd_fsel_i)) begin
                inlen_q  <= bus.cmd_inlen_i;
                fsel_q   <= bus.cmd_fsel_i;
                outlen_q <= bus.cmd_outlen_i;
                rem_q    <= word_count(bus.cmd_inlen_i);
                blk_q    <= '0;
                sq_q     <= '0;
                init_q   <= 1'b1;
                state_q  <= ST_INIT;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_INIT: begin
            // An empty message still needs one padding-only permutation.
            if (rem_q == 64'd0) begin
              perm_q  <= 1'b1;
              state_q <= ST_PERM;
            end else begin
              state_q <= ST_ABSORB;
            end
          end
          ST_ABSORB: begin
            if (absorb_fire_d) begin
              rem_q <= rem_dec_d;
              blk_q <= blk_inc_d;
              if ((blk_inc_d == rate_d) || (rem_dec_d == 64'd0)) begin
                perm_q  <= 1'b1;
                state_q <= ST_PERM;
              end
            end
          end
          ST_PERM: begin
            if (!perm_q && bus.kc_perm_ready_i) begin
              blk_q <= '0;
              sq_q  <= '0;
              if (rem_q != 64'd0) begin
                state_q <= ST_ABSORB;
              end else if (outlen_q == 16'd0) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                st_q    <= 1'b1;
                state_q <= ST_SQUEEZE;
              end
            end
          end
          ST_SQUEEZE: begin
            if (!st_q && bus.kc_dout_valid_i) begin
              hold_q  <= bus.kc_dout_i;
              state_q <= ST_OUT;
            end
          end
          ST_OUT: begin
            if (bus.dst_ready_i) begin
              outlen_q <= outlen_dec_d;
              sq_q     <= sq_inc_d;
              if (outlen_dec_d == 16'd0) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else if (sq_inc_d == rate_d) begin
                perm_q  <= 1'b1;
                state_q <= ST_PERM;
              end else begin
                st_q    <= 1'b1;
                state_q <= ST_SQUEEZE;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef PQCUARK_STREAM_PERF_EN
  logic [31:0] perf_cnt_q;

  // Permutation request counter; survives flush, wraps naturally.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_cnt_q <= '0;
    end else if (perm_q) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end

  assign perf_perm_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_pqcuark_keccak_stream_ctrl.sv
// Self-checking bench for pqcuark_keccak_stream_ctrl: random engine/sink
// timing, expected request/response event order built from the hashing
// rules (rate, word count, output length).
module tb_pqcuark_keccak_stream_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic flush;
  logic busy, done, err;
`ifdef PQCUARK_STREAM_PERF_EN
  logic [31:0] perf_perm_cnt;
`endif

  pqcuark_keccak_stream_ctrl_if bus();

  pqcuark_keccak_stream_ctrl dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .flush_i (flush),
    .bus     (bus),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err)
`ifdef PQCUARK_STREAM_PERF_EN
    ,
    .perf_perm_cnt_o (perf_perm_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [7:0] EV_INIT = 8'd1;
  localparam logic [7:0] EV_VAL  = 8'd2;
  localparam logic [7:0] EV_PERM = 8'd3;
  localparam logic [7:0] EV_ST   = 8'd4;
  localparam logic [7:0] EV_DST  = 8'd5;

  typedef struct packed {
    logic [7:0]  code;
    logic [63:0] data;
  } ev_t;

  ev_t         got_q[$];
  ev_t         exp_q[$];
  logic [63:0] src_tab[$];
  logic [63:0] dout_tab[$];
  int          src_idx, dout_idx;
  int          buf_mode, src_mode, dst_mode;
  int          done_cnt, err_cnt;
  bit          job_chk;
  logic [63:0] cur_inlen;
  logic [2:0]  cur_fsel;
  int          checks, failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tb_rate(input int f);
    case (f)
      0: return 17;
      1: return 9;
      2: return 21;
      default: return 17;
    endcase
  endfunction

  function automatic int count_code(input logic [7:0] code);
    int n = 0;
    foreach (got_q[i]) if (got_q[i].code == code) n++;
    return n;
  endfunction

  // Engine, source and sink models: drive inputs 1 time unit after the edge.
  initial begin
    int perm_wait, st_wait, stall;
    perm_wait = 0; st_wait = 0; stall = 0;
    bus.kc_perm_ready_i   = 1'b1;
    bus.kc_buffer_ready_i = 1'b1;
    bus.kc_dout_valid_i   = 1'b0;
    bus.kc_dout_i         = '0;
    bus.src_valid_i       = 1'b0;
    bus.src_data_i        = '0;
    bus.dst_ready_i       = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.kc_perm_o) begin
        bus.kc_perm_ready_i = 1'b0;
        perm_wait = $urandom_range(1, 4);
      end else if (perm_wait > 0) begin
        perm_wait--;
      end else begin
        bus.kc_perm_ready_i = 1'b1;
      end
      bus.kc_dout_valid_i = 1'b0;
      bus.kc_dout_i       = '0;
      if (bus.kc_st_o) begin
        st_wait = $urandom_range(1, 3);
      end else if (st_wait > 0) begin
        st_wait--;
        if (st_wait == 0) begin
          bus.kc_dout_valid_i = 1'b1;
          bus.kc_dout_i = (dout_idx < dout_tab.size()) ? dout_tab[dout_idx] : 64'h0BAD_0BAD_0BAD_0BAD;
          dout_idx++;
        end
      end else if (bus.dst_valid_o && ($urandom_range(0, 3) == 0)) begin
        bus.kc_dout_valid_i = 1'b1;
        bus.kc_dout_i       = 64'hDEAD_BEEF_0BAD_F00D;
      end
      case (buf_mode)
        0: bus.kc_buffer_ready_i = 1'b1;
        1: bus.kc_buffer_ready_i = ~bus.kc_buffer_ready_i;
        default: bus.kc_buffer_ready_i = 1'($urandom_range(0, 1));
      endcase
      bus.src_valid_i = (src_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.src_data_i  = (src_idx < src_tab.size()) ? src_tab[src_idx] : 64'h5A5A_5A5A_5A5A_5A5A;
      case (dst_mode)
        0: bus.dst_ready_i = 1'b1;
        1: bus.dst_ready_i = 1'($urandom_range(0, 1));
        default: begin
          if (bus.dst_valid_o) begin
            if (stall < 5) begin
              bus.dst_ready_i = 1'b0;
              stall++;
            end else begin
              bus.dst_ready_i = 1'b1;
            end
          end else begin
            stall = 0;
            bus.dst_ready_i = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor: record engine/digest events mid-cycle, check invariants.
  initial begin
    bit          prev_stall, prev_flush;
    logic [63:0] prev_data;
    prev_stall = 1'b0; prev_flush = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("kc_onehot", 64'($countones({bus.kc_init_o, bus.kc_perm_o, bus.kc_st_o, bus.kc_valid_o}) <= 1), 64'd1);
        if (bus.kc_init_o) got_q.push_back('{EV_INIT, 64'd0});
        if (bus.kc_valid_o) got_q.push_back('{EV_VAL, bus.kc_data_o});
        if (bus.src_valid_i && bus.src_ready_o) src_idx++;
        if (bus.kc_perm_o) got_q.push_back('{EV_PERM, 64'd0});
        if (bus.kc_st_o) got_q.push_back('{EV_ST, 64'd0});
        if (bus.dst_valid_o && bus.dst_ready_i) got_q.push_back('{EV_DST, bus.dst_data_o});
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (prev_stall && !prev_flush) begin
          chk("dst_hold_valid", bus.dst_valid_o, 1'b1);
          chk("dst_hold_data", bus.dst_data_o, prev_data);
        end
        if (job_chk && busy) begin
          chk("kc_inlen_hold", bus.kc_inlen_o, cur_inlen);
          chk("kc_fsel_hold", bus.kc_fsel_o, cur_fsel);
        end
        prev_stall = bus.dst_valid_o && !bus.dst_ready_i;
        prev_data  = bus.dst_data_o;
        prev_flush = flush;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] f, input logic [63:0] inlen, input logic [15:0] outlen);
    @(posedge clk); #1;
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_fsel_i   = f;
    bus.cmd_inlen_i  = inlen;
    bus.cmd_outlen_i = outlen;
    @(posedge clk); #1;
    bus.cmd_valid_i  = 1'b0;
  endtask

  task automatic prep_tables(input int words, input int outlen);
    src_tab.delete();
    dout_tab.delete();
    for (int i = 0; i < words; i++) src_tab.push_back({$urandom, $urandom});
    for (int i = 0; i < outlen; i++) dout_tab.push_back({$urandom, $urandom});
    src_idx = 0;
    dout_idx = 0;
    got_q.delete();
  endtask

  // Expected engine/digest event order from the hashing rules alone.
  task automatic build_expected(input int f, input int inlen, input int outlen);
    int rate = tb_rate(f);
    int words = inlen / 8 + ((inlen % 8) != 0 ? 1 : 0);
    exp_q.delete();
    exp_q.push_back('{EV_INIT, 64'd0});
    if (words == 0) exp_q.push_back('{EV_PERM, 64'd0});
    for (int w = 0; w < words; w++) begin
      exp_q.push_back('{EV_VAL, src_tab[w]});
      if (((w + 1) % rate == 0) || (w == words - 1)) exp_q.push_back('{EV_PERM, 64'd0});
    end
    for (int i = 0; i < outlen; i++) begin
      if (i > 0 && (i % rate) == 0) exp_q.push_back('{EV_PERM, 64'd0});
      exp_q.push_back('{EV_ST, 64'd0});
      exp_q.push_back('{EV_DST, dout_tab[i]});
    end
  endtask

  task automatic compare_events(input string tag, input int n);
    int f0 = failures;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_ev_code"}, got_q[i].code, exp_q[i].code);
      chk({tag, "_ev_data"}, got_q[i].data, exp_q[i].data);
      if (failures != f0) break;
    end
  endtask

  task automatic run_job(input string tag, input int f, input int inlen, input int outlen,
                         input int exp_perms);
    int d0, e0, c, words, n;
    words = inlen / 8 + ((inlen % 8) != 0 ? 1 : 0);
    prep_tables(words, outlen);
    build_expected(f, inlen, outlen);
    d0 = done_cnt;
    e0 = err_cnt;
    cur_inlen = 64'(inlen);
    cur_fsel  = 3'(f);
    job_chk = 1'b1;
    send_cmd(3'(f), 64'(inlen), 16'(outlen));
    c = 0;
    while (done_cnt == d0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    cyc(2);
    job_chk = 1'b0;
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_err_pulses"}, 64'(err_cnt - e0), 64'd0);
    chk({tag, "_idle_after"}, busy, 1'b0);
    chk({tag, "_event_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    compare_events(tag, n);
    if (exp_perms >= 0) chk({tag, "_perms"}, 64'(count_code(EV_PERM)), 64'(exp_perms));
  endtask

  initial begin
    int c, d0, e0, sz;
    logic [63:0] big;
`ifdef PQCUARK_STREAM_PERF_EN
    logic [31:0] perf0;
`endif
    checks = 0; failures = 0;
    done_cnt = 0; err_cnt = 0;
    buf_mode = 0; src_mode = 0; dst_mode = 0;
    job_chk = 1'b0; cur_inlen = '0; cur_fsel = '0;
    src_idx = 0; dout_idx = 0;
    rstn = 1'b0; flush = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_fsel_i = '0; bus.cmd_inlen_i = '0; bus.cmd_outlen_i = '0;

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_kc_init", bus.kc_init_o, 1'b0);
    chk("rst_kc_perm", bus.kc_perm_o, 1'b0);
    chk("rst_kc_st", bus.kc_st_o, 1'b0);
    chk("rst_dst_valid", bus.dst_valid_o, 1'b0);
    chk("rst_kc_inlen", bus.kc_inlen_o, 64'd0);
    chk("rst_kc_fsel", bus.kc_fsel_o, 3'd0);
    chk("rst_dst_data", bus.dst_data_o, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc(2);
    chk("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
`ifdef PQCUARK_STREAM_PERF_EN
    chk("rst_perf", perf_perm_cnt, 32'd0);
`endif

    run_job("sha3_256_16B_4w", 0, 16, 4, 1);
    run_job("shake128_200B_0w", 2, 200, 0, 2);
    run_job("shake256_0B_20w", 3, 0, 20, 2);
    buf_mode = 1; dst_mode = 2;
    run_job("sha3_512_toggle_stall", 1, 100, 12, 3);
    buf_mode = 0; dst_mode = 0;

    for (int f = 4; f < 8; f++) begin
      e0 = err_cnt;
      send_cmd(3'(f), 64'd64, 16'd4);
      cyc(2);
      chk($sformatf("illegal_fsel%0d_err", f), 64'(err_cnt - e0), 64'd1);
      chk($sformatf("illegal_fsel%0d_idle", f), busy, 1'b0);
    end

    // Near-maximum message length: word count must not collapse.
    big = 64'hFFFF_FFFF_FFFF_FFF8;
    prep_tables(20, 0);
    exp_q.delete();
    exp_q.push_back('{EV_INIT, 64'd0});
    for (int w = 0; w < 9; w++) exp_q.push_back('{EV_VAL, src_tab[w]});
    exp_q.push_back('{EV_PERM, 64'd0});
    exp_q.push_back('{EV_VAL, src_tab[9]});
    exp_q.push_back('{EV_VAL, src_tab[10]});
    cur_inlen = big; cur_fsel = 3'd1; job_chk = 1'b1;
    send_cmd(3'd1, big, 16'd1);
    c = 0;
    while (got_q.size() < 13 && c < 400) begin
      @(posedge clk);
      c++;
    end
    chk("big_inlen_reached", 64'(got_q.size() >= 13), 64'd1);
    if (got_q.size() >= 13) compare_events("big_inlen", 13);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    job_chk = 1'b0;
    chk("big_flush_idle", busy, 1'b0);

    // Flush mid-absorb, then an illegal command.
`ifdef PQCUARK_STREAM_PERF_EN
    perf0 = perf_perm_cnt;
`endif
    prep_tables(25, 4);
    d0 = done_cnt; e0 = err_cnt;
    cur_inlen = 64'd200; cur_fsel = 3'd0; job_chk = 1'b1;
    send_cmd(3'd0, 64'd200, 16'd4);
    c = 0;
    while (count_code(EV_VAL) < 20 && c < 400) begin
      @(posedge clk);
      c++;
    end
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    job_chk = 1'b0;
    chk("flush_reached_absorb", 64'(count_code(EV_VAL) >= 20), 64'd1);
    chk("flush_idle", busy, 1'b0);
    chk("flush_src_ready", bus.src_ready_o, 1'b0);
    chk("flush_dst_valid", bus.dst_valid_o, 1'b0);
    chk("flush_perm_count", 64'(count_code(EV_PERM)), 64'd1);
    cyc(4);
    chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
`ifdef PQCUARK_STREAM_PERF_EN
    chk("flush_perf", perf_perm_cnt - perf0, 32'd1);
`endif
    send_cmd(3'd5, 64'd8, 16'd1);
    cyc(2);
    chk("flush_next_err", 64'(err_cnt - e0), 64'd1);
    chk("flush_next_idle", busy, 1'b0);

    // Flush coincident with a legal command: command dropped.
    sz = got_q.size();
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b1; bus.cmd_fsel_i = 3'd2; bus.cmd_inlen_i = 64'd8; bus.cmd_outlen_i = 16'd1;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0; flush = 1'b0;
    cyc(2);
    chk("flush_cmd_idle", busy, 1'b0);
    chk("flush_cmd_no_init", 64'(got_q.size()), 64'(sz));

    // Reset in the middle of the squeeze phase.
    prep_tables(1, 30);
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(3'd3, 64'd8, 16'd30);
    c = 0;
    while (count_code(EV_DST) < 3 && c < 600) begin
      @(posedge clk);
      c++;
    end
    #1; rstn = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_dst_valid", bus.dst_valid_o, 1'b0);
    chk("midrst_dst_data", bus.dst_data_o, 64'd0);
    chk("midrst_kc_inlen", bus.kc_inlen_o, 64'd0);
    cyc(1);
    rstn = 1'b1;
    cyc(4);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midrst_no_err", 64'(err_cnt - e0), 64'd0);
    chk("midrst_cmd_ready", bus.cmd_ready_o, 1'b1);

    for (int j = 0; j < 4; j++) begin
      buf_mode = $urandom_range(0, 2);
      src_mode = $urandom_range(0, 1);
      dst_mode = $urandom_range(0, 2);
      run_job($sformatf("rand%0d", j), $urandom_range(0, 3), $urandom_range(0, 300),
              $urandom_range(0, 40), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
